arith_seq_ctrl: RTL and testbench

Sequencer that time-shares a single multi-cycle floating-point core, with a start/done handshake, across the three steps of the amplitude path: i/q divide, multiply by gain Ku, and float-to-integer convert. It accepts one i/q sample per request and drives the core's opcode and operands step by step. It emits the converted result with a one-cycle valid strobe and holds the gain register written over the Avalon-style address/data bus. It replaces three dedicated core instances with one, and sits between the i/q demodulator and the output filter.

---
 rtl/arith_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_arith_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_seq_ctrl.sv
// Amplitude-path sequencer: one multi-cycle FP core time-shared for divide, gain multiply, convert.
// Define ARITH_SEQ_PENDING_EN to add a one-deep pending sample buffer.
module arith_seq_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter logic [7:0]  OP_DIV      = 8'd7,
  parameter logic [7:0]  OP_MUL      = 8'd4,
  parameter logic [7:0]  OP_CNV      = 8'd1,
  parameter logic [31:0] KU_RESET    = 32'h3F80_0000
) (
  input  logic               clk,
  input  logic               reset_l,
  input  logic               clk_en,
  input  logic               sample_valid,
  input  logic [31:0]        i,
  input  logic [31:0]        q,
  input  logic               wr_en,
  input  logic [2:0]         address,
  input  logic [31:0]        data,
  output logic               core_start,
  output logic [7:0]         core_n,
  output logic [31:0]        core_dataa,
  output logic [31:0]        core_datab,
  input  logic               core_done,
  input  logic [31:0]        core_result,
  output logic signed [31:0] signal_o,
  output logic               valid,
  output logic               busy,
  output logic               overrun,
  output logic               timeout_err
);

  // state  | meaning
  // IDLE   | no sample in flight
  // *_ISS  | one-cycle core_start with step operands
  // *_WAIT | wait core_done or timer terminal count
  // OUT    | publish converted result
  typedef enum logic [2:0] {
    IDLE, DIV_ISS, DIV_WAIT, MUL_ISS, MUL_WAIT, CNV_ISS, CNV_WAIT, OUT
  } state_t;

  localparam int unsigned   TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);

  state_t        state;
  logic [TW-1:0] tmr;
  logic [31:0]   ku, ku_lat, cnv_res;
  logic          start_r;
  logic          in_wait, take_new, take_pend, start_any, ovr_set, tmo_set;
  logic [31:0]   nxt_i, nxt_q, nxt_ku;

  assign busy       = (state != IDLE);
  assign core_start = start_r & clk_en;
  assign in_wait    = (state == DIV_WAIT) || (state == MUL_WAIT) || (state == CNV_WAIT);
  assign tmo_set    = clk_en && in_wait && !core_done && (tmr == '0);
  assign start_any  = take_new || take_pend;

`ifdef ARITH_SEQ_PENDING_EN
  logic        pend_full, can_start, pend_load;
  logic [31:0] pend_i, pend_q, pend_ku;

  // OUT can hand straight over to the next sample, so it counts as a start point.
  assign can_start = (state == IDLE) || (state == OUT);
  assign take_pend = clk_en && can_start && pend_full;
  assign take_new  = clk_en && sample_valid && can_start && !pend_full;
  assign pend_load = clk_en && sample_valid && ((!can_start && !pend_full) || take_pend);
  assign ovr_set   = clk_en && sample_valid && !can_start && pend_full;
  assign nxt_i     = pend_full ? pend_i  : i;
  assign nxt_q     = pend_full ? pend_q  : q;
  assign nxt_ku    = pend_full ? pend_ku : ku;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      pend_full <= 1'b0;
      pend_i    <= '0;
      pend_q    <= '0;
      pend_ku   <= '0;
    end else if (pend_load) begin
      pend_full <= 1'b1;
      pend_i    <= i;
      pend_q    <= q;
      pend_ku   <= ku;
    end else if (take_pend) begin
      pend_full <= 1'b0;
    end
  end
`else
  assign take_pend = 1'b0;
  assign take_new  = clk_en && sample_valid && (state == IDLE);
  assign ovr_set   = clk_en && sample_valid && (state != IDLE);
  assign nxt_i     = i;
  assign nxt_q     = q;
  assign nxt_ku    = ku;
`endif

  // Event set beats a simultaneous software clear.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      ku          <= KU_RESET;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (wr_en && address == 3'd0) ku <= data;
      if (ovr_set) overrun <= 1'b1;
      else if (wr_en && address == 3'd1 && data[0]) overrun <= 1'b0;
      if (tmo_set) timeout_err <= 1'b1;
      else if (wr_en && address == 3'd1 && data[1]) timeout_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state      <= IDLE;
      tmr        <= '0;
      start_r    <= 1'b0;
      core_n     <= OP_DIV;
      core_dataa <= '0;
      core_datab <= '0;
      ku_lat     <= '0;
      cnv_res    <= '0;
      signal_o   <= '0;
      valid      <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (clk_en) begin
        start_r <= 1'b0;
        case (state)
          IDLE, OUT: begin
            if (state == OUT) begin
              valid    <= 1'b1;
              signal_o <= (cnv_res == 32'h7FFF_FFFF || cnv_res == 32'h8000_0000) ? '0 : cnv_res;
            end
            if (start_any) begin
              state      <= DIV_ISS;
              start_r    <= 1'b1;
              core_n     <= OP_DIV;
              core_dataa <= nxt_i;
              core_datab <= nxt_q;
              ku_lat     <= nxt_ku;
            end else begin
              state  <= IDLE;
              core_n <= OP_DIV;
            end
          end
          DIV_ISS: begin tmr <= TMR_LOAD; state <= DIV_WAIT; end
          MUL_ISS: begin tmr <= TMR_LOAD; state <= MUL_WAIT; end
          CNV_ISS: begin tmr <= TMR_LOAD; state <= CNV_WAIT; end
          DIV_WAIT, MUL_WAIT, CNV_WAIT: begin
            if (core_done) begin
              if (state == DIV_WAIT) begin
                state      <= MUL_ISS;
                start_r    <= 1'b1;
                core_n     <= OP_MUL;
                core_dataa <= core_result;
                core_datab <= ku_lat;
              end else if (state == MUL_WAIT) begin
                state      <= CNV_ISS;
                start_r    <= 1'b1;
                core_n     <= OP_CNV;
                core_dataa <= core_result;
                core_datab <= '0;
              end else begin
                state   <= OUT;
                cnv_res <= core_result;
              end
            end else if (tmo_set) begin
              state  <= IDLE;
              core_n <= OP_DIV;
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_arith_seq_ctrl.sv
// Scoreboard bench for arith_seq_ctrl with a fixed-latency model FP core (small exact-integer floats).
`timescale 1ns/1ps
module tb_arith_seq_ctrl;
  localparam int         CORE_LAT = 5;
  localparam logic [7:0] OP_DIV = 8'd7, OP_MUL = 8'd4, OP_CNV = 8'd1;

  logic clk = 1'b0, reset_l = 1'b0, clk_en = 1'b1, sample_valid = 1'b0, wr_en = 1'b0;
  logic [31:0] i = '0, q = '0, data = '0, core_result = '0;
  logic [2:0]  address = '0;
  logic        core_done = 1'b0;
  logic        core_start, valid, busy, overrun, timeout_err;
  logic [7:0]  core_n;
  logic [31:0] core_dataa, core_datab;
  logic signed [31:0] signal_o;

  arith_seq_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset_l(reset_l), .clk_en(clk_en), .sample_valid(sample_valid),
    .i(i), .q(q), .wr_en(wr_en), .address(address), .data(data),
    .core_start(core_start), .core_n(core_n), .core_dataa(core_dataa), .core_datab(core_datab),
    .core_done(core_done), .core_result(core_result), .signal_o(signal_o), .valid(valid),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] val; int cyc; } exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0;
  logic core_mute = 1'b0, cnv_force = 1'b0;
  logic [31:0] cnv_val = '0;

  function automatic int f2i(logic [31:0] f);
    int e, m;
    if (f[30:0] == 31'd0) return 0;
    e = int'(f[30:23]) - 127;
    if (e < 0) return 0;
    m = int'({8'd0, 1'b1, f[22:0]});
    m = (e >= 23) ? (m << (e - 23)) : (m >> (23 - e));
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] i2f(int v);
    logic s;
    int unsigned mag;
    int p;
    if (v == 0) return 32'd0;
    s   = (v < 0);
    mag = s ? int'(-v) : v;
    p   = 31;
    while (p > 0 && !mag[p]) p--;
    return {s, 8'(p + 127), 23'(mag << (23 - p))};
  endfunction

  function automatic logic [31:0] core_calc(logic [7:0] op, logic [31:0] a, logic [31:0] b);
    int x, y;
    x = f2i(a);
    y = f2i(b);
    case (op)
      OP_DIV:  return (y == 0) ? 32'h7FC0_0000 : i2f(x / y);
      OP_MUL:  return i2f(x * y);
      OP_CNV:  return cnv_force ? cnv_val : 32'(x);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // model core: start seen during ISS, done in the CORE_LAT-th cycle after it
  initial begin
    logic [7:0]  op;
    logic [31:0] a, b;
    forever begin
      @(negedge clk);
      if (core_start && !core_mute) begin
        op = core_n; a = core_dataa; b = core_datab;
        repeat (CORE_LAT) @(posedge clk);
        #1 core_done = 1'b1; core_result = core_calc(op, a, b);
        @(posedge clk);
        #1 core_done = 1'b0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: got signal_o=%h at cycle %0d, required no valid", signal_o, cyc);
        end else begin
          e = exp_q.pop_front();
          if (signal_o !== e.val) begin
            errors++;
            $display("FAIL signal_o: got %h required %h", signal_o, e.val);
          end
          if (e.cyc >= 0) begin
            checks++;
            if (cyc != e.cyc) begin
              errors++;
              $display("FAIL valid_latency: got cycle %0d required %0d", cyc, e.cyc);
            end
          end
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic push(logic [31:0] v, int c);
    exp_t e;
    e.val = v; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic send(int a, int b, output int acc);
    @(posedge clk);
    #1 sample_valid = 1'b1; i = i2f(a); q = i2f(b);
    @(posedge clk);
    #1 acc = cyc; sample_valid = 1'b0;
  endtask

  task automatic wr(logic [2:0] adr, logic [31:0] val);
    @(posedge clk);
    #1 wr_en = 1'b1; address = adr; data = val;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic drain(string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_drain: got %0d results outstanding required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200us required finish");
    $fatal(1);
  end

  initial begin
    int acc, acc2, n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_signal_o", signal_o, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_core_n", {24'd0, core_n}, {24'd0, OP_DIV});
    chk("rst_flags", {29'd0, valid, overrun, timeout_err}, 0);
    reset_l = 1'b1;

    send(6, 2, acc); push(32'd3, acc + 19);
    drain("single");

    wr(3'd0, i2f(2));
    send(1, 1, acc); push(32'd2, acc + 19);
    wr(3'd0, i2f(4));
    drain("ku_snapshot");

    wr(3'd0, i2f(1));
    send(-6, 2, acc); push(32'hFFFF_FFFD, acc + 19);
    drain("negative");

    cnv_force = 1'b1; cnv_val = 32'h7FFF_FFFF;
    send(6, 2, acc); push(32'd0, acc + 19);
    drain("sat_pos");
    cnv_force = 1'b0;
    send(6, 2, acc); push(32'd3, acc + 19);
    drain("after_sat");
    cnv_force = 1'b1; cnv_val = 32'h8000_0000;
    send(6, 2, acc); push(32'd0, acc + 19);
    drain("sat_neg");
    cnv_force = 1'b0;

    clk_en = 1'b0;
    send(6, 2, acc);
    repeat (3) @(posedge clk);
    #1 chk("clk_en_low_busy", {31'd0, busy}, 0);
    chk("clk_en_low_overrun", {31'd0, overrun}, 0);
    clk_en = 1'b1;

    send(6, 2, acc); push(32'd3, acc + 23);
    clk_en = 1'b0;
    #1 chk("freeze_core_start", {31'd0, core_start}, 0);
    repeat (4) @(posedge clk);
    #1 clk_en = 1'b1;
    drain("freeze");

    core_mute = 1'b1;
    send(6, 2, acc);
    repeat (15) @(posedge clk);
    #1 chk("timeout_early", {30'd0, busy, timeout_err}, 32'd2);
    repeat (3) @(posedge clk);
    #1 chk("timeout_set", {30'd0, busy, timeout_err}, 32'd1);
    core_mute = 1'b0;
    repeat (8) @(posedge clk);
    wr(3'd1, 32'd2);
    chk("timeout_clear", {30'd0, overrun, timeout_err}, 0);

    send(6, 2, acc); push(32'd3, acc + 19);
    @(posedge clk);
    send(8, 2, acc2);
`ifdef ARITH_SEQ_PENDING_EN
    push(32'd4, acc + 38);
    chk("b2b_no_overrun", {31'd0, overrun}, 0);
`else
    chk("b2b_overrun", {31'd0, overrun}, 1);
`endif
    @(posedge clk);
    send(2, 2, acc2);
    chk("third_overrun", {31'd0, overrun}, 1);
    drain("b2b");
    wr(3'd1, 32'd1);
    chk("overrun_clear", {31'd0, overrun}, 0);

    wr(3'd0, i2f(2));
    send(6, 2, acc);
    n = 0;
    while (!(core_start && core_n == OP_MUL) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL mul_issue_wait: got no MUL start in 100 cycles required start");
    end
    repeat (2) @(posedge clk);
    #2 reset_l = 1'b0;
    #1;
    chk("mid_rst_signal_o", signal_o, 0);
    chk("mid_rst_ctrl", {28'd0, core_start, valid, busy, timeout_err}, 0);
    chk("mid_rst_core_n", {24'd0, core_n}, {24'd0, OP_DIV});
    chk("mid_rst_dataa", core_dataa, 0);
    chk("mid_rst_datab", core_datab, 0);
    repeat (3) @(posedge clk);
    #1 reset_l = 1'b1;
    repeat (10) @(posedge clk);
    send(8, 2, acc); push(32'd4, acc + 19);
    drain("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
